// File: rtl/common_types_pkg.sv
// Shared types for the core memory path: word types, arbiter state and port ids.
package common_types_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WSTRB_W = XLEN / 8;
  localparam int unsigned WADDR_W = XLEN - 2;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [WSTRB_W-1:0] wstrb_t;
  typedef logic [WADDR_W-1:0] waddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    IPORT = 1'b0,
    DPORT = 1'b1
  } arb_port_t;

  // One RAM command as driven onto the ram_* pins.
  typedef struct packed {
    wstrb_t wen;
    word_t  addr;
    word_t  wdata;
  } ram_cmd_t;

  // Byte address rounded down to its containing word.
  function automatic word_t word_base(input word_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Word index of a byte address.
  function automatic waddr_t word_index(input word_t a);
    return a[XLEN-1:2];
  endfunction

endpackage

// File: rtl/ibuf_entry.sv
// One-entry instruction buffer: remembers the last fetched word so stalled
// repeat fetches are served without a RAM access. Tied off when EN=0.
module ibuf_entry
  import common_types_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   fill,
  input  waddr_t fill_addr,
  input  word_t  fill_data,
  input  logic   inval,
  input  waddr_t inval_addr,
  input  waddr_t lookup_addr,
  output logic   hit,
  output word_t  data
);

  if (EN) begin : g_entry
    logic   valid_q, valid_d;
    waddr_t addr_q,  addr_d;
    word_t  data_q,  data_d;

    // Fill on fetch completion; a store to the held word clears it and wins.
    always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (fill) begin
        valid_d = 1'b1;
        addr_d  = fill_addr;
        data_d  = fill_data;
      end
      if (inval && (inval_addr == addr_d)) begin
        valid_d = 1'b0;
      end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        addr_q  <= addr_d;
        data_q  <= data_d;
      end
    end

    assign hit  = valid_q && (lookup_addr == addr_q);
    assign data = data_q;
  end else begin : g_none
    assign hit  = 1'b0;
    assign data = '0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Merges the core's instruction and data ports onto one single-ported RAM
// with a req/ready handshake; round-robin when both ports want the RAM.
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter bit IBUF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iren,
  input  logic [31:0]  iaddr,
  output logic [31:0]  iload,
  output logic         iwait,
  input  logic         dren,
  input  logic [3:0]   dwen,
  input  logic [31:0]  daddr,
  input  logic [31:0]  dstore,
  output logic [31:0]  dload,
  output logic         dwait,
  output logic         ram_req,
  output logic [3:0]   ram_wen,
  output logic [31:0]  ram_addr,
  output logic [31:0]  ram_wdata,
  input  logic [31:0]  ram_rdata,
  input  logic         ram_ready
);

  arb_state_t state_q,      state_d;
  arb_port_t  last_grant_q, last_grant_d;
  word_t      fetch_addr_q, fetch_addr_d;
  logic       ram_req_q,    ram_req_d;
  ram_cmd_t   cmd_q,        cmd_d;

  logic  dreq, ireq, i_done, d_done, i_match, take_i, take_d;
  logic  ibuf_hit;
  word_t ibuf_data;

  assign dreq    = dren | (|dwen);
  assign ireq    = iren & ~ibuf_hit;
  assign i_done  = (state_q == IACC) & ram_ready;
  assign d_done  = (state_q == DACC) & ram_ready;
  assign i_match = i_done & iren & (iaddr == fetch_addr_q);

  // Both requesting: serve the port that did not go last.
  assign take_i  = ireq & (~dreq | (last_grant_q == DPORT));
  assign take_d  = dreq & ~take_i;

  ibuf_entry #(
    .EN (IBUF_EN)
  ) u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .fill        (i_done),
    .fill_addr   (word_index(fetch_addr_q)),
    .fill_data   (ram_rdata),
    .inval       (d_done & (|cmd_q.wen)),
    .inval_addr  (word_index(cmd_q.addr)),
    .lookup_addr (word_index(iaddr)),
    .hit         (ibuf_hit),
    .data        (ibuf_data)
  );

  // Stall and return-data paths back to the core (same-cycle).
  always_comb begin
    iwait = iren & ~(ibuf_hit | i_match);
    iload = '0;
    if (iren && ibuf_hit) begin
      iload = ibuf_data;
    end else if (i_match) begin
      iload = ram_rdata;
    end
    dwait = dreq & ~d_done;
    dload = '0;
    if (d_done && (cmd_q.wen == '0)) begin
      dload = ram_rdata;
    end
  end

  // Arbitration and RAM command next-state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fetch_addr_d = fetch_addr_q;
    ram_req_d    = ram_req_q;
    cmd_d        = cmd_q;
    case (state_q)
      IDLE: begin
        if (take_i) begin
          state_d      = IACC;
          last_grant_d = IPORT;
          fetch_addr_d = iaddr;
          ram_req_d    = 1'b1;
          cmd_d.addr   = word_base(iaddr);
          cmd_d.wen    = '0;
          cmd_d.wdata  = '0;
        end else if (take_d) begin
          state_d      = DACC;
          last_grant_d = DPORT;
          ram_req_d    = 1'b1;
          cmd_d.addr   = word_base(daddr);
          cmd_d.wen    = dwen;
          cmd_d.wdata  = (|dwen) ? dstore : '0;
        end
      end
      IACC, DACC: begin
        if (ram_ready) begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  // State and RAM command registers; reset abandons any open transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= DPORT;
      fetch_addr_q <= '0;
      ram_req_q    <= 1'b0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fetch_addr_q <= fetch_addr_d;
      ram_req_q    <= ram_req_d;
      cmd_q        <= cmd_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_wen   = cmd_q.wen;
  assign ram_addr  = cmd_q.addr;
  assign ram_wdata = cmd_q.wdata;

  // The core must hold its data command while it is being stalled.
  a_dcmd_stable: assert property (@(posedge clk) disable iff (rst)
    dwait |=> ($stable(daddr) && $stable(dwen) && $stable(dstore)));

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a transaction-level reference model.
module tb_ram_arbiter;

  localparam bit IBUF_EN = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iren = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        iwait;
  logic        dren = 1'b0;
  logic [3:0]  dwen = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_req;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.IBUF_EN(IBUF_EN)) dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM contents (sparse, with a deterministic default pattern).
  logic [31:0] mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0], ~w[15:0]};
  endfunction

  // Reference model: open transaction, bus command, fairness, cached word.
  logic        m_busy = 1'b0, m_is_i = 1'b0, m_last_d = 1'b1;
  logic [31:0] m_fetch = '0, m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wen = '0;
  logic        c_valid = 1'b0;
  logic [29:0] c_word = '0;
  logic [31:0] c_data = '0;

  // Values seen in the cycle before the edge being modelled.
  logic        cap_rst = 1'b1, cap_iren = 1'b0, cap_dren = 1'b0, cap_ready = 1'b0;
  logic        cap_dwait = 1'b0, cap_iwait = 1'b0;
  logic [31:0] cap_iaddr = '0, cap_daddr = '0, cap_dstore = '0, cap_rdata = '0;
  logic [3:0]  cap_dwen = '0;

  // Next inputs to apply after the coming edge.
  logic        nx_rst = 1'b1, nx_iren = 1'b0, nx_dren = 1'b0;
  logic [31:0] nx_iaddr = '0, nx_daddr = '0, nx_dstore = '0;
  logic [3:0]  nx_dwen = '0;

  // RAM responder knobs.
  int unsigned fix_lat = 0, stray_pct = 0, rsp_cnt = 0, rsp_lat = 1;
  logic        rsp_busy = 1'b0, force_ready = 1'b0;

  task automatic model_edge();
    logic hit, want_i, want_d;
    logic [31:0] w;
    if (cap_rst) begin
      m_busy = 1'b0; m_last_d = 1'b1; c_valid = 1'b0;
      m_addr = '0; m_wen = '0; m_wdata = '0;
    end else if (m_busy) begin
      if (cap_ready) begin
        if (m_is_i) begin
          if (IBUF_EN) begin
            c_valid = 1'b1; c_word = m_fetch[31:2]; c_data = cap_rdata;
          end
        end else if (m_wen != 4'd0) begin
          w = mem_rd(m_addr[31:2]);
          for (int b = 0; b < 4; b++)
            if (m_wen[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
          mem[m_addr[31:2]] = w;
          if (c_word == m_addr[31:2]) c_valid = 1'b0;
        end
        m_busy = 1'b0;
      end
    end else begin
      hit    = IBUF_EN && c_valid && (cap_iaddr[31:2] == c_word);
      want_i = cap_iren && !hit;
      want_d = cap_dren || (cap_dwen != 4'd0);
      if (want_i && (!want_d || m_last_d)) begin
        m_busy = 1'b1; m_is_i = 1'b1; m_last_d = 1'b0;
        m_fetch = cap_iaddr; m_addr = {cap_iaddr[31:2], 2'b00};
        m_wen = '0; m_wdata = '0;
      end else if (want_d) begin
        m_busy = 1'b1; m_is_i = 1'b0; m_last_d = 1'b1;
        m_addr = {cap_daddr[31:2], 2'b00}; m_wen = cap_dwen;
        m_wdata = (cap_dwen != 4'd0) ? cap_dstore : 32'd0;
      end
    end
  endtask

  task automatic respond();
    ram_ready = 1'b0;
    ram_rdata = $urandom();
    if (ram_req) begin
      if (!rsp_busy) begin
        rsp_busy = 1'b1; rsp_cnt = 0;
        rsp_lat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 4);
      end
      rsp_cnt++;
      if (rsp_cnt == rsp_lat) begin
        ram_ready = 1'b1;
        ram_rdata = mem_rd(ram_addr[31:2]);
      end
    end else begin
      rsp_busy = 1'b0;
      if (force_ready || ($urandom_range(0, 99) < stray_pct)) ram_ready = 1'b1;
      force_ready = 1'b0;
    end
  endtask

  task automatic evaluate();
    logic hit, icomp, dcomp, dreq, e_iwait, e_dwait;
    logic [31:0] e_iload, e_dload;
    hit     = IBUF_EN && c_valid && (iaddr[31:2] == c_word);
    icomp   = m_busy && m_is_i && ram_ready && iren && (iaddr == m_fetch);
    dcomp   = m_busy && !m_is_i && ram_ready;
    dreq    = dren || (dwen != 4'd0);
    e_iwait = iren && !(hit || icomp);
    e_iload = (iren && hit) ? c_data : (icomp ? ram_rdata : 32'd0);
    e_dwait = dreq && !dcomp;
    e_dload = (dcomp && m_wen == 4'd0) ? ram_rdata : 32'd0;
    check("ram_req",   {31'd0, ram_req}, {31'd0, m_busy});
    check("ram_addr",  ram_addr, m_addr);
    check("ram_wen",   {28'd0, ram_wen}, {28'd0, m_wen});
    check("ram_wdata", ram_wdata, m_wdata);
    check("iwait",     {31'd0, iwait}, {31'd0, e_iwait});
    check("iload",     iload, e_iload);
    check("dwait",     {31'd0, dwait}, {31'd0, e_dwait});
    check("dload",     dload, e_dload);
    if (iren && !e_iwait) check("iload_vs_mem", iload, mem_rd(iaddr[31:2]));
    if (dcomp && dreq && m_wen == 4'd0) check("dload_vs_mem", dload, mem_rd(m_addr[31:2]));
    cap_rst = rst; cap_iren = iren; cap_iaddr = iaddr; cap_dren = dren;
    cap_dwen = dwen; cap_daddr = daddr; cap_dstore = dstore;
    cap_ready = ram_ready; cap_rdata = ram_rdata; cap_dwait = dwait; cap_iwait = iwait;
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    respond();
    rst = nx_rst; iren = nx_iren; iaddr = nx_iaddr;
    dren = nx_dren; dwen = nx_dwen; daddr = nx_daddr; dstore = nx_dstore;
    @(negedge clk);
    evaluate();
  endtask

  task automatic idle_inputs();
    nx_iren = 1'b0; nx_dren = 1'b0; nx_dwen = '0;
  endtask

  task automatic reset_dut();
    idle_inputs(); nx_rst = 1'b1; step(); nx_rst = 1'b0; step();
  endtask

  task automatic wait_i(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (!cap_iwait) return;
    end
    check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_d(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (!cap_dwait) return;
    end
    check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h40 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    mem[30'h10] = 32'h0000_0013;
    reset_dut();

    // Fetch with 3-cycle RAM latency, then a repeat fetch that hits.
    fix_lat = 3;
    nx_iren = 1'b1; nx_iaddr = 32'h100;
    wait_i("fetch100");
    step();
    idle_inputs(); step();

    // Both ports together after reset: instruction first, then data.
    reset_dut();
    nx_iren = 1'b1; nx_iaddr = 32'h104; nx_dren = 1'b1; nx_daddr = 32'h44;
    wait_d("both");
    idle_inputs(); step();

    // Redirected fetch: 0x200 in flight, core moves to 0x300.
    fix_lat = 4;
    nx_iren = 1'b1; nx_iaddr = 32'h200;
    step(); step();
    nx_iaddr = 32'h300;
    wait_i("redirect");
    nx_iaddr = 32'h200; step();
    idle_inputs(); step();

    // Buffered word invalidated by a partial store to the same word.
    fix_lat = 0;
    nx_iren = 1'b1; nx_iaddr = 32'h40;
    wait_i("fetch40");
    step();
    idle_inputs(); nx_dwen = 4'b0011; nx_daddr = 32'h42; nx_dstore = 32'h1234_5678;
    wait_d("store42");
    idle_inputs(); nx_iren = 1'b1; nx_iaddr = 32'h40;
    wait_i("refetch40");
    idle_inputs(); step();

    // Full-word write then read back.
    nx_dwen = 4'hF; nx_daddr = 32'h80; nx_dstore = 32'hDEAD_BEEF;
    wait_d("write80");
    idle_inputs(); nx_dren = 1'b1; nx_daddr = 32'h80;
    wait_d("read80");
    idle_inputs(); step();

    // Reset in the middle of a data access, then a stray ready.
    fix_lat = 10;
    nx_dren = 1'b1; nx_daddr = 32'h88;
    step(); step(); step();
    nx_rst = 1'b1; step();
    nx_rst = 1'b0; force_ready = 1'b1; step();
    wait_d("after_rst");
    idle_inputs(); step();
    fix_lat = 0;

    // Random traffic.
    stray_pct = 5;
    for (int n = 0; n < 3000; n++) begin
      nx_rst  = ($urandom_range(0, 299) == 0);
      nx_iren = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 25) nx_iaddr = rand_addr();
      if (!cap_dwait || cap_rst) begin
        case ($urandom_range(0, 3))
          0: begin nx_dren = 1'b0; nx_dwen = '0; end
          1, 2: begin nx_dren = 1'b1; nx_dwen = '0; end
          default: begin
            nx_dren = 1'b0; nx_dwen = 4'($urandom_range(1, 15)); nx_dstore = $urandom();
          end
        endcase
        nx_daddr = rand_addr() | 32'($urandom_range(0, 3));
      end
      step();
    end
    nx_rst = 1'b0; idle_inputs(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sits directly downstream of the pipelined core's cpu_ram_if; merges its instruction-fetch and data ports onto one single-ported RAM with a variable-latency req/ready handshake.
- Generates iwait/dwait back to the core's hazard logic.
- Holds a one-entry instruction buffer so repeated fetches of the same address during pipeline stalls cost no RAM cycles.
- Arbitration: round-robin when both ports request, otherwise first-come.

Parameters:
IBUF_EN, 1, enables the one-entry instruction buffer (0: every fetch goes to RAM)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
iren  in  1  instruction read request
iaddr  in  32  instruction byte address (word aligned)
iload  out  32  instruction data; valid when iren & ~iwait
iwait  out  1  fetch not complete this cycle
dren  in  1  data read request
dwen  in  4  data byte write enables; nonzero = write
daddr  in  32  data byte address
dstore  in  32  store data, already byte-lane aligned
dload  out  32  read data; valid when dren & ~dwait
dwait  out  1  data access not complete this cycle
ram_req  out  1  RAM transaction request, registered
ram_wen  out  4  RAM byte enables, registered
ram_addr  out  32  RAM word address ({addr[31:2],2'b00}), registered
ram_wdata  out  32  RAM write data, registered
ram_rdata  in  32  RAM read data, valid with ram_ready
ram_ready  in  1  one-cycle pulse: transaction complete

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ram_req=0, ram_wen=0, ram_addr=0, ram_wdata=0, last_grant=DATA, ibuf_valid=0. Combinational outputs then give iwait=iren, dwait=dren|(|dwen), iload=dload=0.
- Reset mid-transaction abandons the transaction. The RAM must tolerate ram_req dropping. Any late ram_ready while in IDLE is ignored.
- FSM states: IDLE, IACC, DACC.
- IDLE:
  - dreq=dren|(|dwen).
  - ireq=iren&~ibuf_hit, where ibuf_hit=IBUF_EN&ibuf_valid&(iaddr[31:2]==ibuf_addr).
  - If both dreq and ireq: grant the port not equal to last_grant.
  - Otherwise grant whichever requests.
  - On grant, register ram_addr/ram_wen/ram_wdata and set ram_req=1. ram_wen=0 and ram_wdata=0 for reads and instruction fetches.
  - Latch the granted iaddr as fetch_addr. Set last_grant and move to IACC or DACC.
- IACC/DACC:
  - Hold ram_req and ram_* stable until ram_ready=1.
  - On that edge: ram_req=0, return to IDLE.
  - No back-to-back issue: at least one IDLE cycle between transactions.
- Minimum access latency is 2 cycles: request seen in cycle 0, ram_req high in cycle 1, ram_ready at the earliest in cycle 1, completion in cycle 1.
- Instruction completion (IACC & ram_ready):
  - If IBUF_EN: ibuf_addr=fetch_addr[31:2], ibuf_data=ram_rdata, ibuf_valid=1.
  - If iren & iaddr==fetch_addr: iwait=0 and iload=ram_rdata this cycle (combinational pass-through).
  - Otherwise iwait stays 1 (the fetch was redirected by a flush) and the stale word only fills the buffer.
- Buffer hit: iwait=0 and iload=ibuf_data in the same cycle, with no RAM access. Allowed in any state, including concurrently with a DACC.
- Data completion (DACC & ram_ready): dwait=0. dload=ram_rdata for reads and 0 for writes.
- The core keeps daddr/dwen/dstore stable while dwait=1. A change is a protocol error, flagged by an assertion.
- Coherence: a write completing with daddr[31:2]==ibuf_addr clears ibuf_valid on the same edge as completion. If a buffer fill and a write to that word complete on the same edge, the clear wins; this case can only arise with stale state.
- Simultaneous instruction hit and data completion: both waits are 0 in the same cycle.
- dwait=1 whenever dreq and not completing this cycle. iwait=1 whenever iren and neither hit nor matching completion.

Decomposition:
- common_types_pkg gains arb_state_t (IDLE, IACC, DACC) and arb_port_t (IPORT, DPORT). word_t is reused.
- One sub-module, ibuf_entry: valid/addr/data register with fill, invalidate and hit compare. When IBUF_EN=0, ibuf_entry is tied off so that hit=0.
- The arbiter FSM and RAM registers stay in ram_arbiter.

Test Plan:
- Fetch only, iaddr=0x100, RAM ready 3 cycles after ram_req: ram_addr=0x100 and ram_req high for 3 cycles; iwait drops in the ram_ready cycle with iload=RAM word. The same fetch on the next cycle hits: iwait=0 with no ram_req.
- dren and iren asserted together, last_grant=DATA, from reset: instruction granted first. Data is granted the cycle after the instruction completion plus one IDLE cycle. dwait stays 1 until then.
- Fetch 0x200 in flight, iaddr switched to 0x300 before ram_ready: iwait stays 1 at completion. Buffer holds 0x200, then a new RAM fetch of 0x300 issues.
- Buffer holds 0x40 = 0x00000013. A store with dwen=4'b0011 to daddr=0x42 completes: ibuf_valid clears, and the next fetch of 0x40 goes to RAM.
- Write dwen=4'b1111 to 0x80 with dstore=0xDEADBEEF: ram_wen=4'hF, ram_wdata=0xDEADBEEF, dload=0 at completion. A following read of 0x80 returns 0xDEADBEEF.
- rst=1 raised during DACC: the next cycle has ram_req=0, state IDLE, and a late ram_ready produces no dwait drop.
